fft_top_mul_rnd_sat: RTL
========================

// Module: fft_top_mul_rnd_sat
// PURPOSE
//  Parametrised pipelined multiplier for FFT twiddle/scale paths: din0 x din1 at full precision,
//  right-shift by SHIFT with selectable rounding, saturate to OUT_W, valid-tagged with overflow flags.
//  Drop-in successor to the fixed 15u x 26s DSP multiplier; ce stalls the whole pipe.
// PARAMETERS
//  A_W         15  din0 width
//  B_W         26  din1 width
//  A_SIGNED    0   1: din0 two's complement; 0: unsigned
//  B_SIGNED    1   1: din1 two's complement; 0: unsigned
//  SHIFT       15  result right-shift (0..A_W+B_W-1); 0 = no rounding
//  OUT_W       26  dout width (1..A_W+B_W)
//  ROUND_MODE  1   0: truncate (floor), 1: round half up (+inf), 2: convergent (ties to even)
//  EXTRA_STAGE 0   added output register stages (0..4) for timing
// PORTS
//  clk        in   1      clock, all logic rising-edge
//  reset      in   1      synchronous, active-high
//  ce         in   1      clock enable; 0 freezes every pipeline register
//  in_valid   in   1      din0/din1 carry a sample
//  din0       in   A_W    operand A
//  din1       in   B_W    operand B
//  clr_ovf    in   1      clears ovf_sticky
//  out_valid  out  1      dout/ovf carry a sample
//  dout       out  OUT_W  rounded, saturated product
//  ovf        out  1      this sample was saturated (qualified by out_valid)
//  ovf_sticky out  1      any sample saturated since reset/clr_ovf
// BEHAVIOUR
//  - Reset priority over ce. In reset cycle all valid bits, dout, ovf, ovf_sticky <= 0; data regs <= 0.
//  - Pipe: S1 register din0/din1/in_valid; S2 exact product P (A_W+B_W+1 bits signed, operands
//    sign- or zero-extended per *_SIGNED); S3 round+shift+saturate; then EXTRA_STAGE delay regs.
//  - Latency 3+EXTRA_STAGE ce-high cycles; ce low: no register changes, order/alignment preserved.
//  - Throughput 1 sample per ce-high cycle; no backpressure. Data regs load regardless of in_valid;
//    in_valid only tags samples.
//  - Rounding on P, R = P >>> SHIFT (arithmetic):
//      mode0 R = floor(P/2^SHIFT); mode1 R = floor((P + 2^(SHIFT-1))/2^SHIFT);
//      mode2 as mode1 except exact ties (dropped bits = 100..0) go to even R.
//  - Output signed if A_SIGNED|B_SIGNED, else unsigned. Range signed [-2^(OUT_W-1), 2^(OUT_W-1)-1],
//    unsigned [0, 2^OUT_W-1]. Out of range -> clamp to nearest limit, ovf=1; else ovf=0.
//  - ovf_sticky sets when out_valid&ovf; clears on clr_ovf (ce-independent); set wins if same cycle.
//  - ovf/dout of samples with out_valid=0 are don't-care and never set ovf_sticky.
//  - Reset mid-stream: all in-flight samples discarded; out_valid stays 0 until a new sample
//    travels the full latency after reset deasserts.
// TESTING (defaults unless stated; latency 3)
//  1. din0=0x4000, din1=1000, in_valid=1 -> 3 cycles later out_valid=1, dout=500, ovf=0.
//  2. din0=1, din1=16384/-16384/49152 -> mode1: dout=1/0/2; mode2: 0/0/2; mode0: 0/-1/1.
//  3. OUT_W=16: din0=0x7FFF, din1=2^20 -> dout=32767, ovf=1, ovf_sticky=1; din1=-2^20 -> dout=-32768,
//     ovf=1; then clr_ovf pulse with no new overflow -> ovf_sticky=0; clr_ovf same cycle as
//     overflowing out_valid -> ovf_sticky=1.
//  4. Stream 8 samples, ce=0 for 2 cycles at sample 4 -> outputs frozen during stall, all 8 emerge
//     in order, each exactly 3 ce-high cycles after input, no duplicates/drops.
//  5. reset for 1 cycle with 3 samples in flight -> out_valid=0 next cycle and stays 0 until a
//     post-reset sample arrives 3 cycles later; ovf_sticky=0.
//  6. A_SIGNED=1, EXTRA_STAGE=2: din0=-16384, din1=-65536 -> after 5 cycles dout=32768, ovf=0;
//     in_valid alternating 1/0 -> out_valid reproduces pattern delayed 5 cycles.

Source files
------------

// File: rtl/fft_top_mul_rnd_sat.sv
// fft_top_mul_rnd_sat
//   Pipelined multiplier for FFT twiddle/scale paths. Forms the exact product
//   din0 x din1, shifts it right by SHIFT with selectable rounding, saturates
//   to OUT_W and tags every result with a valid bit and an overflow flag.
//   Latency is 3 + EXTRA_STAGE ce-high cycles. ce low freezes every pipeline
//   register.
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   ce                   clock enable for the whole pipe
//   in_valid, din0, din1 input sample and its operands
//   clr_ovf              clears ovf_sticky (independent of ce)
//   out_valid, dout, ovf output sample, rounded/saturated product, clamp flag
//   ovf_sticky           some valid output was clamped since reset/clr_ovf
module fft_top_mul_rnd_sat #(
    parameter int A_W         = 15,
    parameter int B_W         = 26,
    parameter int A_SIGNED    = 0,
    parameter int B_SIGNED    = 1,
    parameter int SHIFT       = 15,
    parameter int OUT_W       = 26,
    parameter int ROUND_MODE  = 1,
    parameter int EXTRA_STAGE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [A_W-1:0]   din0,
    input  logic [B_W-1:0]   din1,
    input  logic             clr_ovf,
    output logic             out_valid,
    output logic [OUT_W-1:0] dout,
    output logic             ovf,
    output logic             ovf_sticky
);
    // Product width holds any operand combination exactly; one more bit for
    // the rounding increment so it can never wrap.
    localparam int PW = A_W + B_W + 1;
    localparam int RW = PW + 1;
    localparam bit OUT_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

    localparam logic signed [RW-1:0] ONE_V = RW'(1);
    localparam logic signed [RW-1:0] MAX_V = OUT_SIGNED ? ((ONE_V <<< (OUT_W - 1)) - ONE_V)
                                                        : ((ONE_V <<< OUT_W) - ONE_V);
    localparam logic signed [RW-1:0] MIN_V = OUT_SIGNED ? -(ONE_V <<< (OUT_W - 1))
                                                        : '0;

    // Stage 1: operand capture
    logic [A_W-1:0] a_q, a_d;
    logic [B_W-1:0] b_q, b_d;
    logic           v1_q, v1_d;

    // Stage 2: exact product
    logic signed [PW-1:0] prod_q, prod_d;
    logic                 v2_q, v2_d;
    logic signed [PW-1:0] a_ext, b_ext;

    // Stage 3 and the extra delay stages share one array; index 0 is stage 3
    logic [OUT_W-1:0] pipe_dout_q  [EXTRA_STAGE+1];
    logic [OUT_W-1:0] pipe_dout_d  [EXTRA_STAGE+1];
    logic             pipe_ovf_q   [EXTRA_STAGE+1];
    logic             pipe_ovf_d   [EXTRA_STAGE+1];
    logic             pipe_valid_q [EXTRA_STAGE+1];
    logic             pipe_valid_d [EXTRA_STAGE+1];

    logic ovf_sticky_q, ovf_sticky_d;

    // Round / shift / saturate datapath
    logic signed [RW-1:0] prod_ext;
    logic signed [RW-1:0] q_floor;
    logic signed [RW-1:0] r_val;
    logic                 round_inc;
    logic [OUT_W-1:0]     sat_dout;
    logic                 sat_ovf;

    always_comb begin
        a_d  = din0;
        b_d  = din1;
        v1_d = in_valid;
    end

    always_comb begin
        if (A_SIGNED != 0) a_ext = {{(PW-A_W){a_q[A_W-1]}}, a_q};
        else               a_ext = {{(PW-A_W){1'b0}}, a_q};
        if (B_SIGNED != 0) b_ext = {{(PW-B_W){b_q[B_W-1]}}, b_q};
        else               b_ext = {{(PW-B_W){1'b0}}, b_q};
        prod_d = a_ext * b_ext;
        v2_d   = v1_q;
    end

    assign prod_ext = {prod_q[PW-1], prod_q};
    assign q_floor  = prod_ext >>> SHIFT;

    // The increment is decided from the dropped bits: the half bit and
    // whether anything below it is set (a tie is half bit alone).
    generate
        if (SHIFT == 0) begin : g_no_round
            assign round_inc = 1'b0;
        end else begin : g_round
            logic half_bit;
            logic below_nz;
            assign half_bit = prod_q[SHIFT-1];
            if (SHIFT == 1) begin : g_sh1
                assign below_nz = 1'b0;
            end else begin : g_shn
                assign below_nz = |prod_q[SHIFT-2:0];
            end
            always_comb begin
                round_inc = 1'b0;
                if (ROUND_MODE == 1)      round_inc = half_bit;
                else if (ROUND_MODE == 2) round_inc = half_bit & (below_nz | q_floor[0]);
            end
        end
    endgenerate

    assign r_val = q_floor + {{(RW-1){1'b0}}, round_inc};

    always_comb begin
        sat_ovf  = 1'b0;
        sat_dout = r_val[OUT_W-1:0];
        if (r_val > MAX_V) begin
            sat_ovf  = 1'b1;
            sat_dout = MAX_V[OUT_W-1:0];
        end else if (r_val < MIN_V) begin
            sat_ovf  = 1'b1;
            sat_dout = MIN_V[OUT_W-1:0];
        end
    end

    generate
        for (genvar gi = 0; gi <= EXTRA_STAGE; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign pipe_dout_d[gi]  = sat_dout;
                assign pipe_ovf_d[gi]   = sat_ovf;
                assign pipe_valid_d[gi] = v2_q;
            end else begin : g_delay
                assign pipe_dout_d[gi]  = pipe_dout_q[gi-1];
                assign pipe_ovf_d[gi]   = pipe_ovf_q[gi-1];
                assign pipe_valid_d[gi] = pipe_valid_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            v1_q   <= 1'b0;
            prod_q <= '0;
            v2_q   <= 1'b0;
            for (int i = 0; i <= EXTRA_STAGE; i++) begin
                pipe_dout_q[i]  <= '0;
                pipe_ovf_q[i]   <= 1'b0;
                pipe_valid_q[i] <= 1'b0;
            end
        end else if (ce) begin
            a_q          <= a_d;
            b_q          <= b_d;
            v1_q         <= v1_d;
            prod_q       <= prod_d;
            v2_q         <= v2_d;
            pipe_dout_q  <= pipe_dout_d;
            pipe_ovf_q   <= pipe_ovf_d;
            pipe_valid_q <= pipe_valid_d;
        end
    end

    // Sticky flag follows the registered outputs, so it rises the cycle after
    // a clamped sample is presented. Set wins over a simultaneous clear.
    assign ovf_sticky_d = (ovf_sticky_q & ~clr_ovf) | (out_valid & ovf);

    always_ff @(posedge clk) begin
        if (reset) ovf_sticky_q <= 1'b0;
        else       ovf_sticky_q <= ovf_sticky_d;
    end

    assign out_valid  = pipe_valid_q[EXTRA_STAGE];
    assign dout       = pipe_dout_q[EXTRA_STAGE];
    assign ovf        = pipe_ovf_q[EXTRA_STAGE];
    assign ovf_sticky = ovf_sticky_q;

endmodule
